puf_majority_voter: RTL
=======================

PUF_MAJORITY_VOTER -- requirements
Module: puf_majority_voter

Interface
REQ-001 Parameter RESP_W, default 4, width of the ring-oscillator PUF response and of the key.
REQ-002 Parameter NUM_SAMPLES, default 5, number of response samples per evaluation; odd, 3..15.
REQ-003 Parameter SETTLE_CYCLES, default 16, cycles of PUF enable before the first sample; 1..255.
REQ-004 Parameter SAMPLE_INTERVAL, default 8, cycles between successive samples; 1..255.
REQ-005 clk  input  1  single clock; every state element on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 start  input  1  one-cycle request to begin an evaluation.
REQ-008 puf_response  input  RESP_W  raw response from the ring-oscillator PUF top.
REQ-009 puf_enable  output  1  drives the PUF enable input.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 key_out  output  RESP_W  per-bit majority-voted key.
REQ-012 unstable_mask  output  RESP_W  bit high if that response bit differed between samples.
REQ-013 key_valid  output  1  key_out/unstable_mask valid; held until accepted.
REQ-014 key_ready  input  1  consumer accepts the result when high with key_valid.

Function
REQ-015 FSM states: IDLE, SETTLE, SAMPLE, DECIDE, VALID.
REQ-016 IDLE: start=1 -> SETTLE on the next edge; ones counters cleared; puf_enable rises on that same edge.
REQ-017 SETTLE: lasts exactly SETTLE_CYCLES cycles, then SAMPLE.
REQ-018 SAMPLE: an interval counter counts SAMPLE_INTERVAL cycles; on the last cycle of each interval, puf_response is sampled and each bit's ones counter increments if the bit is 1.
REQ-019 After NUM_SAMPLES samples -> DECIDE; puf_enable deasserts on that edge.
REQ-020 Ones counters are $clog2(NUM_SAMPLES+1) bits wide; they never overflow.
REQ-021 DECIDE (one cycle): key_out[i] = (ones[i] > NUM_SAMPLES/2); unstable_mask[i] = (ones[i] != 0 and ones[i] != NUM_SAMPLES); both registered; -> VALID.
REQ-022 VALID: key_valid=1, key_out and unstable_mask stable; key_valid=1 and key_ready=1 -> IDLE with key_valid low on the next edge.
REQ-023 key_valid rises exactly SETTLE_CYCLES + NUM_SAMPLES*SAMPLE_INTERVAL + 2 cycles after the edge that accepts start (defaults: 58).
REQ-024 start outside IDLE is ignored, including start in the same cycle as the VALID handshake.
REQ-025 key_ready while key_valid=0 has no effect.
REQ-026 key_out and unstable_mask keep their last values in IDLE until the next DECIDE.
REQ-027 puf_enable is high exactly in SETTLE and SAMPLE.

Reset
REQ-028 rst=1 at any edge forces IDLE and zeroes counters, puf_enable, busy, key_valid, key_out and unstable_mask; this includes mid-evaluation (puf_enable low after that edge).
REQ-029 rst has priority over start and key_ready in the same cycle.

Structure
REQ-030 The shared package ro_puf_pkg holds the FSM state enum and the default parameter constants.
REQ-031 The per-bit ones counter and vote are one sub-module, puf_bit_voter, instantiated RESP_W times.
REQ-032 The design contains no latches, no combinational loops and no clock gating.

Verification
REQ-033 Constant puf_response=4'b1010, start pulse -> puf_enable high 56 cycles; key_valid at cycle 58; key_out=1010; unstable_mask=0000.
REQ-034 Response pattern 1111,1111,0000,1111,0000 across the five samples -> key_out=1111; unstable_mask=1111.
REQ-035 key_ready held low for 10 cycles after key_valid -> key_valid and outputs are stable throughout; ready=1 -> IDLE next edge.
REQ-036 start re-pulsed during SAMPLE and in the handshake cycle -> ignored; no second evaluation.
REQ-037 rst asserted during SAMPLE sample 3 -> next edge: IDLE, puf_enable=0, key_valid=0; a new start gives a correct full evaluation.
REQ-038 Back-to-back evaluations with different constant responses (0011, then 1100) -> each key is correct, and unstable_mask=0000 both times.

Source files
------------

// File: rtl/ro_puf_pkg.sv
// rtl/ro_puf_pkg.sv - shared FSM state type and default parameters for the PUF key voter
package ro_puf_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DECIDE,
        ST_VALID
    } puf_state_t;

    localparam int DEF_RESP_W          = 4;
    localparam int DEF_NUM_SAMPLES     = 5;
    localparam int DEF_SETTLE_CYCLES   = 16;
    localparam int DEF_SAMPLE_INTERVAL = 8;

endpackage

// File: rtl/puf_majority_voter_if.sv
// rtl/puf_majority_voter_if.sv - request/result handshake between consumer and PUF key voter
interface puf_majority_voter_if #(
    parameter int RESP_W = 4
) ();
    logic              start;
    logic              busy;
    logic [RESP_W-1:0] key_out;
    logic [RESP_W-1:0] unstable_mask;
    logic              key_valid;
    logic              key_ready;

    modport master (
        output start,
        output key_ready,
        input  busy,
        input  key_out,
        input  unstable_mask,
        input  key_valid
    );

    modport slave (
        input  start,
        input  key_ready,
        output busy,
        output key_out,
        output unstable_mask,
        output key_valid
    );
endinterface

// File: rtl/puf_bit_voter.sv
// rtl/puf_bit_voter.sv - per-bit ones counter with registered majority vote and stability flag
module puf_bit_voter #(
    parameter int NUM_SAMPLES = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic sample_en,
    input  logic bit_in,
    input  logic decide,
    output logic key_bit,
    output logic unstable_bit
);
    localparam int CW = $clog2(NUM_SAMPLES + 1);

    logic [CW-1:0] ones;

    always_ff @(posedge clk) begin
        if (rst) begin
            ones         <= '0;
            key_bit      <= 1'b0;
            unstable_bit <= 1'b0;
        end else begin
            if (clear) begin
                ones <= '0;
            end else if (sample_en && bit_in) begin
                ones <= ones + CW'(1);
            end
            // Result registers hold their value until the next decide.
            if (decide) begin
                key_bit      <= (ones > CW'(NUM_SAMPLES / 2));
                unstable_bit <= (ones != '0) && (ones != CW'(NUM_SAMPLES));
            end
        end
    end
endmodule

// File: rtl/puf_majority_voter.sv
// rtl/puf_majority_voter.sv - sequences PUF enable, samples the response and publishes a voted key
module puf_majority_voter
    import ro_puf_pkg::*;
#(
    parameter int RESP_W          = DEF_RESP_W,
    parameter int NUM_SAMPLES     = DEF_NUM_SAMPLES,
    parameter int SETTLE_CYCLES   = DEF_SETTLE_CYCLES,
    parameter int SAMPLE_INTERVAL = DEF_SAMPLE_INTERVAL
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [RESP_W-1:0]    puf_response,
    output logic                 puf_enable,
    puf_majority_voter_if.slave  bus
);
    localparam int SW = $clog2(NUM_SAMPLES + 1);

    puf_state_t    state;
    logic [7:0]    cnt;
    logic [SW-1:0] samp_cnt;
    logic          clear;
    logic          sample_en;
    logic          decide;
    logic [RESP_W-1:0] key_vec;
    logic [RESP_W-1:0] mask_vec;

    assign clear     = (state == ST_IDLE) && bus.start;
    assign sample_en = (state == ST_SAMPLE) && (cnt == 8'(SAMPLE_INTERVAL - 1));
    assign decide    = (state == ST_DECIDE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            samp_cnt      <= '0;
            puf_enable    <= 1'b0;
            bus.busy      <= 1'b0;
            bus.key_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        state      <= ST_SETTLE;
                        cnt        <= '0;
                        samp_cnt   <= '0;
                        puf_enable <= 1'b1;
                        bus.busy   <= 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (cnt == 8'(SETTLE_CYCLES - 1)) begin
                        state <= ST_SAMPLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                ST_SAMPLE: begin
                    if (sample_en) begin
                        cnt      <= '0;
                        samp_cnt <= samp_cnt + SW'(1);
                        if (samp_cnt == SW'(NUM_SAMPLES - 1)) begin
                            state      <= ST_DECIDE;
                            puf_enable <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                ST_DECIDE: begin
                    state <= ST_VALID;
                end
                ST_VALID: begin
                    // key_valid follows one cycle after the result registers settle.
                    if (!bus.key_valid) begin
                        bus.key_valid <= 1'b1;
                    end else if (bus.key_ready) begin
                        bus.key_valid <= 1'b0;
                        bus.busy      <= 1'b0;
                        state         <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < RESP_W; i++) begin : g_voter
        puf_bit_voter #(
            .NUM_SAMPLES(NUM_SAMPLES)
        ) u_voter (
            .clk         (clk),
            .rst         (rst),
            .clear       (clear),
            .sample_en   (sample_en),
            .bit_in      (puf_response[i]),
            .decide      (decide),
            .key_bit     (key_vec[i]),
            .unstable_bit(mask_vec[i])
        );
    end

    assign bus.key_out       = key_vec;
    assign bus.unstable_mask = mask_vec;
endmodule
